// File: rtl/interrupt_sequencer.sv
// BRK/IRQ/NMI/reset micro-sequencer: six bus cycles after the 0x00 opcode fetch
// that push PC and status to the stack, fetch the vector and load the PC.
module interrupt_sequencer #(
    parameter logic [7:0]  STACK_PAGE   = 8'h01,
    parameter logic [15:0] NMI_VECTOR   = 16'hFFFA,
    parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
    parameter logic [15:0] IRQ_VECTOR   = 16'hFFFE
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        enableFFs,
    input  logic        start,
    input  logic        hwInterrupt,
    input  logic        nmiRunning,
    input  logic        resetRunning,
    input  logic [15:0] pcIn,
    input  logic [7:0]  psrIn,
    input  logic [7:0]  stackPointer,
    input  logic [7:0]  externalDB,
    output logic [15:0] addressOut,
    output logic [7:0]  dataOut,
    output logic        writeEnable,
    output logic        spDecrement,
    output logic        pcLoad,
    output logic [15:0] pcNext,
    output logic        setIFlag,
    output logic        loadNextInstruction,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, T1_PAD, T2_PCH, T3_PCL, T4_PSR, T5_VLO, T6_VHI
    } state_t;

    state_t      state;
    logic [15:0] ret_addr;
    logic [15:0] vec_addr;
    logic [7:0]  vec_lo;
    logic        hw;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            ret_addr <= '0;
            vec_addr <= '0;
            vec_lo   <= '0;
            hw       <= 1'b0;
        end else if (enableFFs) begin
            case (state)
                IDLE: if (start) begin
                    state    <= T1_PAD;
                    // a fetched BRK skips its padding byte; an injected one returns to pcIn
                    ret_addr <= pcIn + {15'd0, ~hwInterrupt};
                    hw       <= hwInterrupt;
                end
                T1_PAD: state <= T2_PCH;
                T2_PCH: state <= T3_PCL;
                T3_PCL: state <= T4_PSR;
                T4_PSR: begin
                    state <= T5_VLO;
                    // late NMI still wins over an IRQ/BRK already in flight
                    if (resetRunning)    vec_addr <= RESET_VECTOR;
                    else if (nmiRunning) vec_addr <= NMI_VECTOR;
                    else                 vec_addr <= IRQ_VECTOR;
                end
                T5_VLO: begin
                    state  <= T6_VHI;
                    vec_lo <= externalDB;
                end
                T6_VHI:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        addressOut          = '0;
        dataOut             = '0;
        writeEnable         = 1'b0;
        spDecrement         = 1'b0;
        pcLoad              = 1'b0;
        pcNext              = '0;
        setIFlag            = 1'b0;
        loadNextInstruction = 1'b0;
        busy                = (state != IDLE);
        case (state)
            T1_PAD: addressOut = pcIn;
            T2_PCH, T3_PCL, T4_PSR: begin
                addressOut  = {STACK_PAGE, stackPointer};
                writeEnable = enableFFs & ~resetRunning;
                spDecrement = enableFFs;
                if (state == T2_PCH)      dataOut = ret_addr[15:8];
                else if (state == T3_PCL) dataOut = ret_addr[7:0];
                else                      dataOut = {psrIn[7:6], 1'b1, ~hw, psrIn[3:0]};
            end
            T5_VLO: begin
                addressOut = vec_addr;
                setIFlag   = enableFFs;
            end
            T6_VHI: begin
                addressOut          = vec_addr + 16'd1;
                pcNext              = {externalDB, vec_lo};
                pcLoad              = enableFFs;
                loadNextInstruction = enableFFs;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Random + directed bench for interrupt_sequencer against a step-counter model.
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        nrst, enableFFs, start, hwInterrupt, nmiRunning, resetRunning;
    logic [15:0] pcIn;
    logic [7:0]  psrIn, stackPointer, externalDB, db_key;
    logic [15:0] addressOut, pcNext;
    logic [7:0]  dataOut;
    logic        writeEnable, spDecrement, pcLoad, setIFlag, loadNextInstruction, busy;

    logic        sp_load_req;
    logic [7:0]  sp_load_val;

    int total = 0;
    int bad   = 0;

    interrupt_sequencer dut (
        .clk(clk), .nrst(nrst), .enableFFs(enableFFs), .start(start),
        .hwInterrupt(hwInterrupt), .nmiRunning(nmiRunning), .resetRunning(resetRunning),
        .pcIn(pcIn), .psrIn(psrIn), .stackPointer(stackPointer), .externalDB(externalDB),
        .addressOut(addressOut), .dataOut(dataOut), .writeEnable(writeEnable),
        .spDecrement(spDecrement), .pcLoad(pcLoad), .pcNext(pcNext), .setIFlag(setIFlag),
        .loadNextInstruction(loadNextInstruction), .busy(busy)
    );

    always #5 clk = ~clk;

    // memory: fixed vector bytes, everything else scrambled by a per-cycle key
    always_comb begin
        case (addressOut)
            16'hFFFA: externalDB = 8'h00;
            16'hFFFB: externalDB = 8'h90;
            16'hFFFC: externalDB = 8'h00;
            16'hFFFD: externalDB = 8'hC0;
            16'hFFFE: externalDB = 8'h00;
            16'hFFFF: externalDB = 8'h80;
            default:  externalDB = addressOut[7:0] ^ db_key;
        endcase
    end

    always @(posedge clk) begin
        if (sp_load_req)      stackPointer <= sp_load_val;
        else if (spDecrement) stackPointer <= stackPointer - 8'd1;
    end

    // reference model: position in the six-cycle sequence plus captured values
    int          m_step;
    logic [15:0] m_ret, m_vec;
    logic [7:0]  m_vlo;
    logic        m_hw;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_step <= 0; m_ret <= 16'h0; m_vec <= 16'h0; m_vlo <= 8'h0; m_hw <= 1'b0;
        end else if (enableFFs) begin
            if (m_step == 0) begin
                if (start) begin
                    m_step <= 1;
                    m_ret  <= pcIn + (hwInterrupt ? 16'd0 : 16'd1);
                    m_hw   <= hwInterrupt;
                end
            end else begin
                m_step <= (m_step == 6) ? 0 : m_step + 1;
                if (m_step == 4)
                    m_vec <= resetRunning ? 16'hFFFC : (nmiRunning ? 16'hFFFA : 16'hFFFE);
                if (m_step == 5) m_vlo <= externalDB;
            end
        end
    end

    function automatic logic [45:0] model_out();
        logic [15:0] a, pn;
        logic [7:0]  d;
        logic        we, sd, pl, si, ln, b;
        a = 16'h0; pn = 16'h0; d = 8'h0;
        we = 1'b0; sd = 1'b0; pl = 1'b0; si = 1'b0; ln = 1'b0;
        b = (m_step != 0);
        case (m_step)
            1: a = pcIn;
            2, 3, 4: begin
                a  = {8'h01, stackPointer};
                we = enableFFs & !resetRunning;
                sd = enableFFs;
                if (m_step == 2)      d = m_ret[15:8];
                else if (m_step == 3) d = m_ret[7:0];
                else                  d = ((psrIn | 8'h20) & 8'hEF) | (m_hw ? 8'h00 : 8'h10);
            end
            5: begin a = m_vec; si = enableFFs; end
            6: begin
                a = m_vec + 16'd1; pn = {externalDB, m_vlo};
                pl = enableFFs; ln = enableFFs;
            end
            default: ;
        endcase
        return {a, d, we, sd, pl, pn, si, ln, b};
    endfunction

    // bus activity log, read by directed checks as deltas
    logic [23:0] wr_q[$];
    int          spd_n = 0, pl_n = 0, seti_n = 0, busy_n = 0;
    logic [15:0] seti_addr, pl_addr, pl_next;

    always @(negedge clk) begin
        if (writeEnable) wr_q.push_back({addressOut, dataOut});
        if (spDecrement) spd_n <= spd_n + 1;
        if (busy)        busy_n <= busy_n + 1;
        if (setIFlag) begin seti_n <= seti_n + 1; seti_addr <= addressOut; end
        if (pcLoad) begin pl_n <= pl_n + 1; pl_addr <= addressOut; pl_next <= pcNext; end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            check("cycle", {addressOut, dataOut, writeEnable, spDecrement, pcLoad, pcNext,
                            setIFlag, loadNextInstruction, busy}, model_out());
        end
    endtask

    task automatic load_sp(input logic [7:0] v);
        sp_load_val = v; sp_load_req = 1'b1; tick(); sp_load_req = 1'b0;
    endtask

    task automatic run_seq();
        start = 1'b1; tick(); start = 1'b0;
        repeat (7) tick();
    endtask

    int wb, sb, pb, bb;

    task automatic mark();
        wb = wr_q.size(); sb = spd_n; pb = pl_n; bb = busy_n;
    endtask

    task automatic main_seq();
        nrst = 1'b0; enableFFs = 1'b1; start = 1'b0; hwInterrupt = 1'b0;
        nmiRunning = 1'b0; resetRunning = 1'b0; pcIn = 16'h1234; psrIn = 8'h00;
        db_key = 8'h00; sp_load_req = 1'b0; sp_load_val = 8'hFD;
        repeat (2) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_addr", addressOut, 16'h0);
        check("rst_strobes", {writeEnable, spDecrement, pcLoad, setIFlag, loadNextInstruction}, 5'h0);
        nrst = 1'b1;
        tick();

        // software BRK
        load_sp(8'hFD); mark(); hwInterrupt = 1'b0; run_seq();
        check("brk_nwr", wr_q.size() - wb, 3);
        check("brk_w0", wr_q[wb], 24'h01FD12);
        check("brk_w1", wr_q[wb+1], 24'h01FC35);
        check("brk_w2", wr_q[wb+2], 24'h01FB30);
        check("brk_pcnext", pl_next, 16'h8000);
        check("brk_pcload_n", pl_n - pb, 1);

        // IRQ
        load_sp(8'hFD); mark(); hwInterrupt = 1'b1; run_seq();
        check("irq_w0", wr_q[wb], 24'h01FD12);
        check("irq_w1", wr_q[wb+1], 24'h01FC34);
        check("irq_w2", wr_q[wb+2], 24'h01FB20);
        check("irq_vlo_addr", seti_addr, 16'hFFFE);
        check("irq_vhi_addr", pl_addr, 16'hFFFF);

        // reset sequence: three decrements, no writes
        mark(); resetRunning = 1'b1; run_seq(); resetRunning = 1'b0;
        check("rst_seq_nwr", wr_q.size() - wb, 0);
        check("rst_seq_spd", spd_n - sb, 3);
        check("rst_seq_vlo", seti_addr, 16'hFFFC);
        check("rst_seq_vhi", pl_addr, 16'hFFFD);
        check("rst_seq_pc", pl_next, 16'hC000);

        // NMI arriving during T3 redirects an IRQ
        load_sp(8'hFD); mark(); hwInterrupt = 1'b1;
        start = 1'b1; tick(); start = 1'b0; tick(); tick();
        nmiRunning = 1'b1; repeat (5) tick(); nmiRunning = 1'b0;
        check("nmi_vlo", seti_addr, 16'hFFFA);
        check("nmi_vhi", pl_addr, 16'hFFFB);
        check("nmi_pc", pl_next, 16'h9000);
        check("nmi_psr", wr_q[wb+2], 24'h01FB20);

        // stall in T3
        load_sp(8'hFD); mark(); hwInterrupt = 1'b0;
        start = 1'b1; tick(); start = 1'b0; tick(); tick();
        enableFFs = 1'b0; repeat (3) tick(); enableFFs = 1'b1; repeat (5) tick();
        check("stall_len", busy_n - bb, 9);
        check("stall_nwr", wr_q.size() - wb, 3);
        check("stall_pcl", wr_q[wb+1], 24'h01FC35);

        // return address wraps
        load_sp(8'hFD); mark(); pcIn = 16'hFFFF; hwInterrupt = 1'b0; run_seq();
        check("wrap_w0", wr_q[wb], 24'h01FD00);
        check("wrap_w1", wr_q[wb+1], 24'h01FC00);
        pcIn = 16'h1234;

        // async reset during T4
        load_sp(8'hFD); mark(); hwInterrupt = 1'b1;
        start = 1'b1; tick(); start = 1'b0; tick(); tick(); tick();
        nrst = 1'b0; #1;
        check("areset_busy", busy, 1'b0);
        check("areset_strobes", {writeEnable, spDecrement, addressOut}, 18'h0);
        #1 nrst = 1'b1;
        repeat (8) tick();
        check("areset_nopcload", pl_n - pb, 0);
        check("areset_nwr", wr_q.size() - wb, 2);
        mark(); run_seq();
        check("areset_restart_len", busy_n - bb, 6);
        check("areset_restart_pl", pl_n - pb, 1);

        // randomized traffic, checked each cycle by compare_loop
        for (int i = 0; i < 3000; i++) begin
            start        = ($urandom_range(0, 3) == 0);
            hwInterrupt  = 1'($urandom);
            nmiRunning   = ($urandom_range(0, 7) == 0);
            resetRunning = ($urandom_range(0, 9) == 0);
            enableFFs    = ($urandom_range(0, 4) != 0);
            pcIn         = 16'($urandom);
            psrIn        = 8'($urandom);
            db_key       = 8'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #1 nrst = 1'b0;
                #1 nrst = 1'b1;
            end
            tick();
        end
        repeat (2) tick();
    endtask

    initial begin
        fork
            compare_loop();
            main_seq();
        join_any
        disable fork;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
